// File: rtl/vga_sig_gen.sv
// VGA timing generator: divides CLK by four into a pixel rate, scans h/v counters,
// addresses a 4x-scaled 1-bit frame buffer and registers sync/colour per pixel.
module vga_sig_gen #(
  parameter int HVIS = 640,
  parameter int HFP  = 16,
  parameter int HSP  = 96,
  parameter int HBP  = 48,
  parameter int VVIS = 480,
  parameter int VFP  = 10,
  parameter int VSP  = 2,
  parameter int VBP  = 33
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] CONFIG_COLOURS,
  output logic [14:0] DPR_ADDR,
  input  logic        DPR_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        FRAME_START
);

  localparam int HTOT = HVIS + HFP + HSP + HBP;
  localparam int VTOT = VVIS + VFP + VSP + VBP;

  localparam logic [9:0] H_LAST     = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST     = 10'(VTOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(HVIS);
  localparam logic [9:0] V_VIS_END  = 10'(VVIS);
  localparam logic [9:0] HS_START   = 10'(HVIS + HFP);
  localparam logic [9:0] HS_END     = 10'(HVIS + HFP + HSP);
  localparam logic [9:0] VS_START   = 10'(VVIS + VFP);
  localparam logic [9:0] VS_END     = 10'(VVIS + VFP + VSP);

  logic [1:0] div;
  logic       pix_en;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_last;
  logic       v_last;
  logic       visible;
  logic       hs_next;
  logic       vs_next;
  logic [7:0] colour_next;
  logic       frame_start_next;

  assign pix_en = (div == 2'd3);
  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div <= 2'd0;
    end else begin
      div <= div + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (pix_en) begin
      if (h_last) begin
        hc <= 10'd0;
        if (v_last) begin
          vc <= 10'd0;
        end else begin
          vc <= vc + 10'd1;
        end
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Each frame-buffer cell covers a 4x4 block of screen pixels.
  assign DPR_ADDR = {vc[8:2], hc[9:2]};

  always_comb begin
    visible          = (hc < H_VIS_END) && (vc < V_VIS_END);
    hs_next          = !((hc >= HS_START) && (hc < HS_END));
    vs_next          = !((vc >= VS_START) && (vc < VS_END));
    colour_next      = 8'h00;
    if (visible) begin
      colour_next = DPR_DATA ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0];
    end
    // Decoded one CLK early so the registered pulse lines up with the wrapping PIX_EN.
    frame_start_next = (div == 2'd2) && h_last && v_last;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_COLOUR <= 8'h00;
    end else if (pix_en) begin
      VGA_HS     <= hs_next;
      VGA_VS     <= vs_next;
      VGA_COLOUR <= colour_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_vga_sig_gen.sv
// Directed bench for vga_sig_gen: a default-timing instance for line and addressing
// behaviour, and a shrunken-timing instance so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sig_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_full_n = 1'b0;
  logic [15:0] cfg_full = 16'hE003;
  logic [14:0] addr_full;
  logic        dpr_full = 1'b0;
  logic        hs_full, vs_full, fs_full;
  logic [7:0]  colour_full;

  logic        rst_small_n = 1'b0;
  logic [15:0] cfg_small = 16'hE003;
  logic [14:0] addr_small;
  logic        dpr_small = 1'b1;
  logic        hs_small, vs_small, fs_small;
  logic [7:0]  colour_small;

  int unsigned full_edges;
  int unsigned small_edges;
  int total  = 0;
  int passed = 0;

  vga_sig_gen dut_full (
    .CLK            (clk),
    .RESET_N        (rst_full_n),
    .CONFIG_COLOURS (cfg_full),
    .DPR_ADDR       (addr_full),
    .DPR_DATA       (dpr_full),
    .VGA_HS         (hs_full),
    .VGA_VS         (vs_full),
    .VGA_COLOUR     (colour_full),
    .FRAME_START    (fs_full)
  );

  // Shrunken timing: HTOT = 24, VTOT = 20, 1920 CLKs per frame.
  vga_sig_gen #(
    .HVIS(16), .HFP(2), .HSP(3), .HBP(3),
    .VVIS(12), .VFP(2), .VSP(2), .VBP(4)
  ) dut_small (
    .CLK            (clk),
    .RESET_N        (rst_small_n),
    .CONFIG_COLOURS (cfg_small),
    .DPR_ADDR       (addr_small),
    .DPR_DATA       (dpr_small),
    .VGA_HS         (hs_small),
    .VGA_VS         (vs_small),
    .VGA_COLOUR     (colour_small),
    .FRAME_START    (fs_small)
  );

  // Frame-buffer model: a single set pixel at 0x0102, one CLK read latency.
  always @(posedge clk) dpr_full <= (addr_full == 15'h0102);

  always @(posedge clk or negedge rst_full_n) begin
    if (!rst_full_n) full_edges <= 0;
    else             full_edges <= full_edges + 1;
  end

  always @(posedge clk or negedge rst_small_n) begin
    if (!rst_small_n) small_edges <= 0;
    else              small_edges <= small_edges + 1;
  end

  task automatic wait_full(input int unsigned e);
    int guard = 0;
    while (full_edges < e && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (full_edges < e) begin
      total++;
      $display("[TB] FAIL wait_full: reached edge %0d, required %0d", full_edges, e);
    end
  endtask

  task automatic wait_small(input int unsigned e);
    int guard = 0;
    while (small_edges < e && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (small_edges < e) begin
      total++;
      $display("[TB] FAIL wait_small: reached edge %0d, required %0d", small_edges, e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (hs_full !== 1'b1) $display("[TB] FAIL reset_hs: got %b want 1", hs_full); else passed++;
    total++; if (vs_full !== 1'b1) $display("[TB] FAIL reset_vs: got %b want 1", vs_full); else passed++;
    total++; if (colour_full !== 8'h00) $display("[TB] FAIL reset_colour: got %h want 00", colour_full); else passed++;
    total++; if (addr_full !== 15'h0000) $display("[TB] FAIL reset_addr: got %h want 0000", addr_full); else passed++;
    total++; if (fs_full !== 1'b0) $display("[TB] FAIL reset_fs: got %b want 0", fs_full); else passed++;
    rst_full_n = 1'b1;
    wait_full(3);
    total++; if (colour_full !== 8'h00) $display("[TB] FAIL pre_first_pix_colour: got %h want 00", colour_full); else passed++;
    wait_full(4);
    total++; if (colour_full !== 8'h03) $display("[TB] FAIL first_pix_colour_0_0: got %h want 03", colour_full); else passed++;
    wait_full(15);
    total++; if (addr_full !== 15'h0000) $display("[TB] FAIL addr_hc3: got %h want 0000", addr_full); else passed++;
    wait_full(16);
    total++; if (addr_full !== 15'h0001) $display("[TB] FAIL addr_hc4: got %h want 0001", addr_full); else passed++;
  endtask

  task automatic test_line_timing();
    wait_full(2563);
    total++; if (colour_full !== 8'h03) $display("[TB] FAIL last_visible_colour: got %h want 03", colour_full); else passed++;
    wait_full(2564);
    total++; if (colour_full !== 8'h00) $display("[TB] FAIL hblank_colour: got %h want 00", colour_full); else passed++;
    wait_full(2627);
    total++; if (hs_full !== 1'b1) $display("[TB] FAIL hs_before_fall: got %b want 1", hs_full); else passed++;
    wait_full(2628);
    total++; if (hs_full !== 1'b0) $display("[TB] FAIL hs_first_fall: got %b want 0", hs_full); else passed++;
    wait_full(3011);
    total++; if (hs_full !== 1'b0) $display("[TB] FAIL hs_end_of_pulse: got %b want 0", hs_full); else passed++;
    wait_full(3012);
    total++; if (hs_full !== 1'b1) $display("[TB] FAIL hs_rise: got %b want 1", hs_full); else passed++;
    wait_full(5827);
    total++; if (hs_full !== 1'b1) $display("[TB] FAIL hs_before_second_fall: got %b want 1", hs_full); else passed++;
    wait_full(5828);
    total++; if (hs_full !== 1'b0) $display("[TB] FAIL hs_second_fall: got %b want 0", hs_full); else passed++;
    total++; if (vs_full !== 1'b1) $display("[TB] FAIL vs_line1: got %b want 1", vs_full); else passed++;
  endtask

  task automatic test_addressing();
    wait_full(12831);
    total++; if (addr_full !== 15'h0101) $display("[TB] FAIL addr_7_4: got %h want 0101", addr_full); else passed++;
    wait_full(12832);
    total++; if (addr_full !== 15'h0102) $display("[TB] FAIL addr_8_4: got %h want 0102", addr_full); else passed++;
  endtask

  task automatic test_colour();
    wait_full(12835);
    total++; if (colour_full !== 8'h03) $display("[TB] FAIL colour_7_4: got %h want 03", colour_full); else passed++;
    wait_full(12836);
    total++; if (colour_full !== 8'hE0) $display("[TB] FAIL colour_8_4: got %h want E0", colour_full); else passed++;
    wait_full(12848);
    total++; if (colour_full !== 8'hE0) $display("[TB] FAIL colour_11_4: got %h want E0", colour_full); else passed++;
    wait_full(12852);
    total++; if (colour_full !== 8'h03) $display("[TB] FAIL colour_12_4: got %h want 03", colour_full); else passed++;
    cfg_full = 16'h5AC3;
    wait_full(12856);
    total++; if (colour_full !== 8'hC3) $display("[TB] FAIL colour_cfg_change: got %h want C3", colour_full); else passed++;
  endtask

  task automatic test_small_hs();
    @(negedge clk);
    rst_small_n = 1'b1;
    wait_small(75);
    total++; if (hs_small !== 1'b1) $display("[TB] FAIL small_hs_before: got %b want 1", hs_small); else passed++;
    wait_small(76);
    total++; if (hs_small !== 1'b0) $display("[TB] FAIL small_hs_fall: got %b want 0", hs_small); else passed++;
    wait_small(87);
    total++; if (hs_small !== 1'b0) $display("[TB] FAIL small_hs_end: got %b want 0", hs_small); else passed++;
    wait_small(88);
    total++; if (hs_small !== 1'b1) $display("[TB] FAIL small_hs_rise: got %b want 1", hs_small); else passed++;
  endtask

  task automatic test_blanking();
    wait_small(1060);
    total++; if (colour_small !== 8'hE0) $display("[TB] FAIL small_colour_0_11: got %h want E0", colour_small); else passed++;
    wait_small(1116);
    total++; if (addr_small !== 15'h0203) $display("[TB] FAIL small_addr_15_11: got %h want 0203", addr_small); else passed++;
    wait_small(1120);
    total++; if (colour_small !== 8'hE0) $display("[TB] FAIL small_colour_15_11: got %h want E0", colour_small); else passed++;
    wait_small(1124);
    total++; if (colour_small !== 8'h00) $display("[TB] FAIL small_hblank_16_11: got %h want 00", colour_small); else passed++;
    wait_small(1156);
    total++; if (colour_small !== 8'h00) $display("[TB] FAIL small_vblank_0_12: got %h want 00", colour_small); else passed++;
  endtask

  task automatic test_frame_timing();
    wait_small(1347);
    total++; if (vs_small !== 1'b1) $display("[TB] FAIL small_vs_before: got %b want 1", vs_small); else passed++;
    wait_small(1348);
    total++; if (vs_small !== 1'b0) $display("[TB] FAIL small_vs_fall: got %b want 0", vs_small); else passed++;
    wait_small(1539);
    total++; if (vs_small !== 1'b0) $display("[TB] FAIL small_vs_end: got %b want 0", vs_small); else passed++;
    wait_small(1540);
    total++; if (vs_small !== 1'b1) $display("[TB] FAIL small_vs_rise: got %b want 1", vs_small); else passed++;
    wait_small(1918);
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL fs1_before: got %b want 0", fs_small); else passed++;
    wait_small(1919);
    total++; if (fs_small !== 1'b1) $display("[TB] FAIL fs1_pulse: got %b want 1", fs_small); else passed++;
    wait_small(1920);
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL fs1_width: got %b want 0", fs_small); else passed++;
    wait_small(3838);
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL fs2_before: got %b want 0", fs_small); else passed++;
    wait_small(3839);
    total++; if (fs_small !== 1'b1) $display("[TB] FAIL fs2_pulse: got %b want 1", fs_small); else passed++;
    wait_small(3840);
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL fs2_width: got %b want 0", fs_small); else passed++;
  endtask

  task automatic test_mid_frame_reset();
    wait_small(4361);
    total++; if (colour_small !== 8'hE0) $display("[TB] FAIL pre_reset_colour: got %h want E0", colour_small); else passed++;
    total++; if (addr_small !== 15'h0102) $display("[TB] FAIL pre_reset_addr: got %h want 0102", addr_small); else passed++;
    rst_small_n = 1'b0;
    #1;
    total++; if (colour_small !== 8'h00) $display("[TB] FAIL async_reset_colour: got %h want 00", colour_small); else passed++;
    total++; if (addr_small !== 15'h0000) $display("[TB] FAIL async_reset_addr: got %h want 0000", addr_small); else passed++;
    total++; if (hs_small !== 1'b1 || vs_small !== 1'b1) $display("[TB] FAIL async_reset_sync: got hs=%b vs=%b want 1 1", hs_small, vs_small); else passed++;
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL async_reset_fs: got %b want 0", fs_small); else passed++;
    repeat (2) @(negedge clk);
    rst_small_n = 1'b1;
    wait_small(3);
    total++; if (colour_small !== 8'h00) $display("[TB] FAIL rerelease_pre_pix: got %h want 00", colour_small); else passed++;
    wait_small(4);
    total++; if (colour_small !== 8'hE0) $display("[TB] FAIL rerelease_pix_0_0: got %h want E0", colour_small); else passed++;
    wait_small(1918);
    total++; if (fs_small !== 1'b0) $display("[TB] FAIL rerelease_fs_before: got %b want 0", fs_small); else passed++;
    wait_small(1919);
    total++; if (fs_small !== 1'b1) $display("[TB] FAIL rerelease_fs_pulse: got %b want 1", fs_small); else passed++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_addressing();
    test_colour();
    test_small_hs();
    test_blanking();
    test_frame_timing();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_sig_gen.md
VGA_SIG_GEN -- requirements
Module: vga_sig_gen

Interface
REQ-001 The module SHALL have parameters (name, default, meaning), one per line below.
- HVIS, 640, visible pixels per line.
- HFP, 16, horizontal front porch in pixels.
- HSP, 96, horizontal sync pulse in pixels.
- HBP, 48, horizontal back porch in pixels.
- VVIS, 480, visible lines per frame.
- VFP, 10, vertical front porch in lines.
- VSP, 2, vertical sync pulse in lines.
- VBP, 33, vertical back porch in lines.
REQ-002 The module SHALL have ports (name, direction, width, meaning), one per line below.
- CLK, in, 1, system clock (100 MHz). This is the only clock.
- RESET_N, in, 1, asynchronous active-low reset.
- CONFIG_COLOURS, in, 16, [15:8] foreground colour, [7:0] background colour.
- DPR_ADDR, out, 15, frame-buffer read-port address, {Y[6:0], X[7:0]}.
- DPR_DATA, in, 1, frame-buffer read data. Valid 1 CLK after DPR_ADDR changes.
- VGA_HS, out, 1, horizontal sync, active low.
- VGA_VS, out, 1, vertical sync, active low.
- VGA_COLOUR, out, 8, pixel colour.
- FRAME_START, out, 1, one-CLK pulse at start of each frame.

Function
REQ-003 A 2-bit divider SHALL count CLK cycles, with PIX_EN=1 when the divider equals 3.
- Pixel rate is CLK/4 (25 MHz).
REQ-004 The horizontal counter HC (10 bits) SHALL advance on PIX_EN.
- Range 0..HTOT-1, where HTOT = HVIS+HFP+HSP+HBP = 800.
- On reaching HTOT-1 it wraps to 0.
REQ-005 The vertical counter VC (10 bits) SHALL increment on PIX_EN only when HC wraps.
- Range 0..VTOT-1, where VTOT = 525.
- On reaching VTOT-1 it wraps to 0 in the same cycle HC wraps.
REQ-006 DPR_ADDR SHALL be combinational from the counters: {VC[8:2], HC[9:2]}.
- Each frame-buffer pixel maps to 4x4 screen pixels (160x120 image).
- DPR_ADDR is held constant for 4 CLKs per screen pixel.
REQ-007 On each PIX_EN, the module SHALL register outputs from the current HC/VC and DPR_DATA.
- All registered outputs therefore lag the counters by exactly one pixel period (4 CLKs).
- VGA_HS, VGA_VS and VGA_COLOUR SHALL remain mutually aligned.
REQ-008 VGA_HS SHALL be registered as 0 when HVIS+HFP <= HC < HVIS+HFP+HSP (656..751), else 1.
REQ-009 VGA_VS SHALL be registered as 0 when VVIS+VFP <= VC < VVIS+VFP+VSP (490..491), else 1.
REQ-010 VGA_COLOUR SHALL be registered as follows:
- Visible area (HC<HVIS and VC<VVIS): CONFIG_COLOURS[15:8] if DPR_DATA=1, else CONFIG_COLOURS[7:0].
- Outside the visible area: 8'h00, regardless of DPR_DATA.
REQ-011 CONFIG_COLOURS SHALL be sampled at every PIX_EN with no extra registering.
- A change therefore takes effect from the next pixel.
REQ-012 FRAME_START SHALL be 1 for exactly one CLK, in the CLK where PIX_EN=1 and HC=HTOT-1 and VC=VTOT-1.
- This is the cycle in which the counters wrap to (0,0).
- It is 0 at all other times.
REQ-013 DPR_ADDR values SHALL remain within the buffer range in the visible area.
- X <= 159, Y <= 119.
- Outside the visible area the address is don't-care but still computed per REQ-006.

Reset
REQ-014 While RESET_N=0, registers SHALL be forced asynchronously to the following values:
- divider = 0, HC = 0, VC = 0.
- VGA_HS = 1, VGA_VS = 1.
- VGA_COLOUR = 8'h00, FRAME_START = 0.
- Consequently DPR_ADDR = 15'h0000.
REQ-015 After RESET_N deasserts, the first PIX_EN SHALL occur on the 4th rising CLK edge.
- Timing restarts from HC=0, VC=0 with no partial-line artefacts, including after a reset asserted mid-frame.

Verification
REQ-016 The bench SHALL cover the directed scenarios below.
- Reset release: RESET_N 0->1 -> HS=1, VS=1, COLOUR=00, ADDR=0000. First PIX_EN at the 4th edge, then HC=1.
- Line timing: free-run -> HS low for exactly 384 CLKs. HS falling edges 3200 CLKs apart. First HS fall 657*4 CLKs after reset release.
- Frame timing: free-run -> VS low for 6400 CLKs. VS period 1,680,000 CLKs. FRAME_START pulses 1,680,000 CLKs apart, each 1 CLK wide.
- Addressing: when HC=8, VC=4 -> DPR_ADDR = 15'h0102. When HC=639, VC=479 -> DPR_ADDR = {7'd119, 8'd159}.
- Colour/blanking: CONFIG_COLOURS = 16'hE003, model RAM returns 1 at 0x0102 and 0 elsewhere. Expected results:
  - Pixel (8,4): E0.
  - Pixel (0,0): 03.
  - Every pixel with HC >= 640 or VC >= 480: 00, even with DPR_DATA forced to 1.
- Mid-frame reset: pull RESET_N low at VC=200, HC=300 -> outputs reach reset values within the same CLK without waiting for an edge. After release, the next FRAME_START arrives after exactly 1,680,000 CLKs.
